morph_window_filter: RTL and testbench
======================================

// Module: morph_window_filter
// PURPOSE
//  Streaming greyscale/binary morphology: erosion (KxK min) or dilation (KxK max)
//  over a raster frame. Provides valid/ready handshakes on both sides and an
//  internal end-of-frame flush. Sits between binarisation/threshold stages and
//  downstream contour/label stages in the image pipeline.
//  Binary images (0 / all-ones) fall out naturally as a special case.
// PARAMETERS
//  IMAGE_WIDTH   320  pixels per line (>= KSIZE)
//  IMAGE_HEIGHT  464  lines per frame (>= KSIZE)
//  DATA_WIDTH    8    bits per pixel
//  KSIZE         3    square kernel side; legal values 3 or 5; R = KSIZE/2
// PORTS
//  clk        in   1           clock, rising edge
//  rst_n      in   1           reset, asynchronous, active-low
//  mode       in   1           0 = erode (min), 1 = dilate (max); sampled on accepted in_sof beat
//  in_valid   in   1           input pixel valid
//  in_ready   out  1           block accepts input this cycle
//  in_data    in   DATA_WIDTH  input pixel, raster order
//  in_sof     in   1           marks pixel (0,0) of a frame
//  out_valid  out  1           output pixel valid
//  out_ready  in   1           downstream accepts output
//  out_data   out  DATA_WIDTH  filtered pixel
//  out_sof    out  1           marks output pixel (0,0)
//  out_eol    out  1           marks last pixel of each output line
//  sync_err   out  1           1-cycle pulse: in_sof received mid-frame
// BEHAVIOUR
//  Reset: out_valid = out_sof = out_eol = sync_err = 0, out_data = 0, in_ready = 0,
//   FSM = IDLE. Line-buffer contents are don't-care after reset.
//  Global enable ce = !out_valid | out_ready. Every pipeline stage advances only on ce.
//   With out_ready held low, out_data/out_sof/out_eol stay stable.
//  FSM:
//   IDLE:  in_ready = ce. Beats without in_sof are accepted and dropped.
//          Accepted beat with in_sof: latch mode, col = row = 0 -> RUN.
//   RUN:   in_ready = ce. Each accepted beat is written to the (KSIZE-1) line buffers
//          and the window, then col/row advance. After pixel (H-1,W-1) -> FLUSH.
//   FLUSH: in_ready = 0. On each ce, one phantom beat is injected; R*W+R beats total.
//          After the last phantom beat -> IDLE.
//  Window taps outside the image (row<0, row>=H, col<0, col>=W) take the identity value:
//   all-ones for erode, 0 for dilate. Border pixels are therefore computed from their
//   in-image neighbours only; no forced background value.
//  Output pixel (r,c) is formed when input (r+R, c+R) is accepted, or from its phantom
//   substitute. out_valid rises on the 2nd ce after that beat: 1 window register plus
//   1 min/max reduction register. Exactly W*H outputs per frame, in raster order.
//  out_sof on output (0,0); out_eol on every output with c = W-1.
//  Comparisons are unsigned DATA_WIDTH. There is no arithmetic growth.
//  in_sof accepted while in RUN (other than on (0,0)):
//   - sync_err pulses.
//   - Partial-frame outputs not yet emitted are discarded; pending out_valid clears.
//   - Counters restart; this beat is pixel (0,0) of the new frame; mode is re-latched.
//  in_sof during FLUSH is not accepted (in_ready = 0) and is held by the source.
//  A new frame may start in IDLE on the cycle after FLUSH ends; no other inter-frame gap.
//  rst_n low mid-frame aborts immediately: no outputs, returns to reset state.
// TESTING
//  1. W=8,H=6,K=3, erode, 4x4 all-ones square at (1..4,1..4) on 0
//     -> only (2..3,2..3) = 255; 48 outputs; out_sof once; out_eol 6 times.
//  2. Same frame, dilate, single 255 pixel at (0,0)
//     -> 255 at (0..1,0..1), else 0 (border uses identity, no wraparound).
//  3. K=5, erode, greyscale ramp p = 10*r + c -> out(r,c) = 10*max(r-2,0) + max(c-2,0).
//  4. Random out_ready (50%) and in_valid gaps on test 3
//     -> identical output sequence; out_data stable while stalled.
//  5. in_sof injected at pixel (3,5), then a full frame -> sync_err = 1 for 1 cycle;
//     next out_sof is followed by exactly W*H outputs matching the new frame.
//  6. rst_n pulsed mid-FLUSH -> out_valid = 0 next cycle; subsequent frame output correct.

Source files
------------

// File: rtl/morph_window_filter.sv
// Streaming KxK erosion (min) / dilation (max) over a raster frame.
// Line buffers plus a KxK window feed a registered min/max reduction; an end-of-frame flush drains the tail.
module morph_window_filter #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 464,
  parameter int DATA_WIDTH   = 8,
  parameter int KSIZE        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  sync_err
);

  localparam int R    = KSIZE / 2;
  localparam int FILL = R * IMAGE_WIDTH + R;
  localparam int CW   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RWD  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int FW   = $clog2(FILL + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the payload holds while valid is high and ready is low.

  logic [1:0]            state;
  logic                  alive;
  logic                  mode_r;
  logic [CW-1:0]         in_col;
  logic [RWD-1:0]        in_row;
  logic [FW-1:0]         fill_cnt;
  logic [FW-1:0]         flush_cnt;
  logic [CW-1:0]         o_col;
  logic [RWD-1:0]        o_row;
  logic                  s1_valid;
  logic                  s1_mode;
  logic [CW-1:0]         s1_col;
  logic [RWD-1:0]        s1_row;
  logic [DATA_WIDTH-1:0] lb  [KSIZE-1][IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] win [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] red;

  logic ce, accept, start, resync, run_beat, flush_beat, beat, emit, last_pix;
  logic [CW-1:0]         beat_col;
  logic [DATA_WIDTH-1:0] beat_pix;
  int rr, cc;

  assign ce         = !out_valid || out_ready;
  assign in_ready   = alive && ce && (state != ST_FLUSH);
  assign accept     = in_valid && in_ready;
  assign start      = accept && in_sof;
  assign resync     = start && (state == ST_RUN);
  assign run_beat   = accept && !in_sof && (state == ST_RUN);
  assign flush_beat = ce && (state == ST_FLUSH);
  assign beat       = start || run_beat || flush_beat;
  assign emit       = !start && (fill_cnt == FW'(FILL));
  assign last_pix   = run_beat && (in_row == RWD'(IMAGE_HEIGHT - 1)) &&
                      (in_col == CW'(IMAGE_WIDTH - 1));
  assign beat_col   = start ? '0 : in_col;
  assign beat_pix   = (state == ST_FLUSH) ? '0 : in_data;

  // Control, counters and the two pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alive     <= 1'b0;
      mode_r    <= 1'b0;
      in_col    <= '0;
      in_row    <= '0;
      fill_cnt  <= '0;
      flush_cnt <= '0;
      o_col     <= '0;
      o_row     <= '0;
      s1_valid  <= 1'b0;
      s1_mode   <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      alive    <= 1'b1;
      sync_err <= resync;
      if (beat) begin
        if (start) begin
          state     <= ST_RUN;
          mode_r    <= mode;
          in_col    <= CW'(1);
          in_row    <= '0;
          fill_cnt  <= FW'(1);
          flush_cnt <= '0;
          o_col     <= '0;
          o_row     <= '0;
        end else begin
          if (in_col == CW'(IMAGE_WIDTH - 1)) begin
            in_col <= '0;
            if (state == ST_RUN) in_row <= in_row + 1'b1;
          end else begin
            in_col <= in_col + 1'b1;
          end
          if (!emit) fill_cnt <= fill_cnt + 1'b1;
          if (emit) begin
            if (o_col == CW'(IMAGE_WIDTH - 1)) begin
              o_col <= '0;
              o_row <= (o_row == RWD'(IMAGE_HEIGHT - 1)) ? '0 : o_row + 1'b1;
            end else begin
              o_col <= o_col + 1'b1;
            end
          end
          if (last_pix) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end
          if (flush_beat) begin
            flush_cnt <= flush_cnt + 1'b1;
            if (flush_cnt == FW'(FILL - 1)) state <= ST_IDLE;
          end
        end
      end
      if (ce) begin
        s1_valid <= beat && emit;
        if (beat && emit) begin
          s1_row  <= o_row;
          s1_col  <= o_col;
          s1_mode <= mode_r;
        end
        out_valid <= s1_valid && !resync;
        out_sof   <= s1_valid && !resync && (s1_row == '0) && (s1_col == '0);
        out_eol   <= s1_valid && !resync && (s1_col == CW'(IMAGE_WIDTH - 1));
        if (s1_valid) out_data <= red;
      end
    end
  end

  // Line buffers hold the previous KSIZE-1 rows; the window holds the last KSIZE column vectors.
  always_ff @(posedge clk) begin
    if (beat) begin
      lb[0][beat_col] <= beat_pix;
      for (int j = 1; j < KSIZE - 1; j++) lb[j][beat_col] <= lb[j-1][beat_col];
      for (int m = 0; m < KSIZE - 1; m++) win[m] <= win[m+1];
      win[KSIZE-1][KSIZE-1] <= beat_pix;
      for (int i = 0; i < KSIZE - 1; i++) win[KSIZE-1][i] <= lb[KSIZE-2-i][beat_col];
    end
  end

  // Columns that wrapped across a line edge and rows outside the frame fall back to the identity.
  always_comb begin
    red = s1_mode ? '0 : '1;
    rr  = 0;
    cc  = 0;
    for (int m = 0; m < KSIZE; m++) begin
      for (int i = 0; i < KSIZE; i++) begin
        rr = int'(s1_row) - R + i;
        cc = int'(s1_col) - R + m;
        if (rr >= 0 && rr < IMAGE_HEIGHT && cc >= 0 && cc < IMAGE_WIDTH) begin
          if (s1_mode) begin
            if (win[m][i] > red) red = win[m][i];
          end else begin
            if (win[m][i] < red) red = win[m][i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_morph_window_filter.sv
// Directed bench for morph_window_filter: K=3 and K=5 instances on an 8x6 frame,
// scoreboard of hand-derived expected pixels with sof/eol flags.
module tb_morph_window_filter;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          mode = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1, rand_ready = 1'b0, sel = 1'b0;

  logic          ir3, ov3, os3, oe3, se3, ir5, ov5, os5, oe5, se5;
  logic [DW-1:0] od3, od5;

  morph_window_filter #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(DW), .KSIZE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid & ~sel), .in_ready(ir3),
    .in_data(in_data), .in_sof(in_sof), .out_valid(ov3), .out_ready(sel ? 1'b1 : out_ready),
    .out_data(od3), .out_sof(os3), .out_eol(oe3), .sync_err(se3));

  morph_window_filter #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(DW), .KSIZE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid & sel), .in_ready(ir5),
    .in_data(in_data), .in_sof(in_sof), .out_valid(ov5), .out_ready(sel ? out_ready : 1'b1),
    .out_data(od5), .out_sof(os5), .out_eol(oe5), .sync_err(se5));

  logic          cur_in_ready, cur_out_valid, cur_out_sof, cur_out_eol, cur_sync_err;
  logic [DW-1:0] cur_out_data;
  assign cur_in_ready  = sel ? ir5 : ir3;
  assign cur_out_valid = sel ? ov5 : ov3;
  assign cur_out_data  = sel ? od5 : od3;
  assign cur_out_sof   = sel ? os5 : os3;
  assign cur_out_eol   = sel ? oe5 : oe3;
  assign cur_sync_err  = sel ? se5 : se3;

  int n_cmp = 0, n_err = 0, n_out = 0, n_sync = 0;
  bit discard = 1'b0;
  bit stalled = 1'b0;
  logic [DW-1:0] held = '0;
  logic [DW+1:0] exp_q[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] src_pix(input int p, input int r, input int c);
    case (p)
      1:       return (r >= 1 && r <= 4 && c >= 1 && c <= 4) ? 8'd255 : 8'd0;
      2:       return (r == 0 && c == 0) ? 8'd255 : 8'd0;
      default: return 8'(10 * r + c);
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_pix(input int p, input int r, input int c);
    case (p)
      1:       return (r >= 2 && r <= 3 && c >= 2 && c <= 3) ? 8'd255 : 8'd0;
      2:       return (r <= 1 && c <= 1) ? 8'd255 : 8'd0;
      default: return 8'(10 * ((r > 2) ? r - 2 : 0) + ((c > 2) ? c - 2 : 0));
    endcase
  endfunction

  task automatic push_frame(input int p);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back({(r == 0 && c == 0), (c == W - 1), exp_pix(p, r, c)});
  endtask

  // driver tasks
  task automatic drive_beat(input logic [DW-1:0] d, input bit sof, input bit m);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_sof = sof; mode = m;
    @(negedge clk);
    while (!cur_in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check_val("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input int p, input bit m, input int npix, input bit gaps);
    for (int idx = 0; idx < npix; idx++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      drive_beat(src_pix(p, idx / W, idx % W), idx == 0, m);
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_val(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // scoreboard
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (cur_sync_err) begin
        n_sync++;
        discard = 1'b0;
      end
      if (stalled) begin
        check_val("stall_valid", cur_out_valid, 1);
        check_val("stall_data", cur_out_data, held);
      end
      stalled = cur_out_valid && !out_ready;
      held    = cur_out_data;
      if (cur_out_valid && out_ready && !discard) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("out_data", cur_out_data, e[DW-1:0]);
          check_val("out_sof", cur_out_sof, e[DW+1]);
          check_val("out_eol", cur_out_eol, e[DW]);
          n_out++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", ov3, 0);
    check_val("rst_out_sof", os3, 0);
    check_val("rst_out_eol", oe3, 0);
    check_val("rst_sync_err", se3, 0);
    check_val("rst_out_data", od3, 0);
    check_val("rst_in_ready", ir3, 0);
    check_val("rst_in_ready5", ir5, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // erode 4x4 square; leading beats without sof are dropped
    for (int i = 0; i < 3; i++) drive_beat(8'hAA, 1'b0, 1'b0);
    n_out = 0;
    push_frame(1);
    send_frame(1, 1'b0, W * H, 1'b0);
    wait_drain("drain_erode");
    check_val("count_erode", n_out, W * H);

    // dilate single corner pixel
    n_out = 0;
    push_frame(2);
    send_frame(2, 1'b1, W * H, 1'b0);
    wait_drain("drain_dilate");
    check_val("count_dilate", n_out, W * H);

    // K=5 erode on a ramp
    sel = 1'b1;
    n_out = 0;
    push_frame(3);
    send_frame(3, 1'b0, W * H, 1'b0);
    wait_drain("drain_k5");
    check_val("count_k5", n_out, W * H);

    // same ramp with backpressure and input gaps
    rand_ready = 1'b1;
    n_out = 0;
    push_frame(3);
    send_frame(3, 1'b0, W * H, 1'b1);
    wait_drain("drain_k5_stall");
    check_val("count_k5_stall", n_out, W * H);
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // sof injected at pixel (3,5), then a full frame
    sel = 1'b0;
    n_sync = 0;
    discard = 1'b1;
    send_frame(1, 1'b0, 3 * W + 5, 1'b0);
    push_frame(1);
    n_out = 0;
    send_frame(1, 1'b0, W * H, 1'b0);
    wait_drain("drain_resync");
    check_val("sync_err_cycles", n_sync, 1);
    check_val("count_resync", n_out, W * H);

    // reset asserted during flush
    push_frame(1);
    send_frame(1, 1'b0, W * H, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_out_valid", ov3, 0);
    check_val("abort_in_ready", ir3, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_out = 0;
    push_frame(2);
    send_frame(2, 1'b1, W * H, 1'b0);
    wait_drain("drain_after_reset");
    check_val("count_after_reset", n_out, W * H);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
